// File: rtl/ext_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_responder
// Summary  : Off-chip side of the 8051 multiplexed bus. Latches the ALE address
//            and serves PSEN/RD/WR strobes against a synchronous memory port.
// Revision : 1.0 - initial release
// ============================================================================
module ext_bus_responder #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ale,
    input  logic              psen_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [7:0]        p0_in,
    input  logic [7:0]        p2_in,
    output logic [7:0]        p0_out,
    output logic              p0_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_code,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic              protocol_err
);

    localparam logic [2:0] c_MEM_LAT = 3'(MEM_LAT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LATCHED   = 3'd1,
        S_RD_WAIT   = 3'd2,
        S_RD_DRIVE  = 3'd3,
        S_WR_ACTIVE = 3'd4
    } state_t;

    state_t      r_state, w_state_d;
    logic        r_ale_q;
    logic [7:0]  r_addr_lo, r_addr_hi;
    logic [2:0]  r_lat_cnt, w_lat_cnt_d;
    logic        r_rd_en, w_rd_en_d;
    logic        r_wr_en, w_wr_en_d;
    logic        r_err, w_err_d;
    logic        r_oe, w_oe_d;
    logic [7:0]  r_p0_out, w_p0_out_d;
    logic        r_code, w_code_d;
    logic [7:0]  r_wdata, w_wdata_d;

    logic        w_ale_fall;
    logic        w_serve_high;
    logic        w_multi;
    logic [15:0] w_addr16;

    assign w_ale_fall   = r_ale_q & ~ale;
    // The strobe that started the read is remembered through mem_code.
    assign w_serve_high = r_code ? psen_n : rd_n;
    assign w_multi      = (!psen_n && !rd_n) || (!psen_n && !wr_n) || (!rd_n && !wr_n);
    assign w_addr16     = {r_addr_hi, r_addr_lo};

    generate
        if (ADDR_W == 16) begin : g_addr_exact
            assign mem_addr = w_addr16;
        end else if (ADDR_W > 16) begin : g_addr_zext
            assign mem_addr = {{(ADDR_W-16){1'b0}}, w_addr16};
        end else begin : g_addr_trunc
            assign mem_addr = w_addr16[ADDR_W-1:0];
        end
    endgenerate

    // Transparent address latch: follows P0/P2 whenever ALE is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ale_q   <= 1'b0;
            r_addr_lo <= 8'h00;
            r_addr_hi <= 8'h00;
        end else begin
            r_ale_q <= ale;
            if (ale) begin
                r_addr_lo <= p0_in;
                r_addr_hi <= p2_in;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_lat_cnt_d = r_lat_cnt;
        w_rd_en_d   = 1'b0;
        w_wr_en_d   = 1'b0;
        w_err_d     = 1'b0;
        w_oe_d      = r_oe;
        w_p0_out_d  = r_p0_out;
        w_code_d    = r_code;
        w_wdata_d   = r_wdata;
        case (r_state)
            S_IDLE: begin
                w_oe_d = 1'b0;
                if (w_ale_fall) w_state_d = S_LATCHED;
            end
            S_LATCHED: begin
                w_oe_d = 1'b0;
                if (ale) begin
                    w_state_d = S_IDLE;
                end else if (!psen_n || !rd_n) begin
                    w_err_d     = w_multi;
                    w_rd_en_d   = 1'b1;
                    w_code_d    = ~psen_n;
                    w_lat_cnt_d = 3'd0;
                    w_state_d   = S_RD_WAIT;
                end else if (!wr_n) begin
                    w_code_d  = 1'b0;
                    w_wdata_d = p0_in;
                    w_state_d = S_WR_ACTIVE;
                end
            end
            S_RD_WAIT: begin
                if (ale) begin
                    w_err_d   = 1'b1;
                    w_oe_d    = 1'b0;
                    w_state_d = S_IDLE;
                end else if (w_serve_high) begin
                    w_state_d = S_IDLE;
                end else if (r_lat_cnt == c_MEM_LAT) begin
                    w_p0_out_d = mem_rdata;
                    w_oe_d     = 1'b1;
                    w_state_d  = S_RD_DRIVE;
                end else begin
                    w_lat_cnt_d = r_lat_cnt + 3'd1;
                end
            end
            S_RD_DRIVE: begin
                if (ale) begin
                    w_err_d   = 1'b1;
                    w_oe_d    = 1'b0;
                    w_state_d = S_IDLE;
                end else if (w_serve_high) begin
                    w_oe_d    = 1'b0;
                    w_state_d = S_IDLE;
                end
            end
            S_WR_ACTIVE: begin
                if (ale) begin
                    w_err_d   = 1'b1;
                    w_state_d = S_IDLE;
                end else if (!wr_n) begin
                    w_wdata_d = p0_in;
                end else begin
                    w_wr_en_d = 1'b1;
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_oe_d    = 1'b0;
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 3'd0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_err     <= 1'b0;
            r_oe      <= 1'b0;
            r_p0_out  <= 8'h00;
            r_code    <= 1'b0;
            r_wdata   <= 8'h00;
        end else begin
            r_state   <= w_state_d;
            r_lat_cnt <= w_lat_cnt_d;
            r_rd_en   <= w_rd_en_d;
            r_wr_en   <= w_wr_en_d;
            r_err     <= w_err_d;
            r_oe      <= w_oe_d;
            r_p0_out  <= w_p0_out_d;
            r_code    <= w_code_d;
            r_wdata   <= w_wdata_d;
        end
    end

    assign p0_out       = r_p0_out;
    assign p0_oe        = r_oe;
    assign mem_code     = r_code;
    assign mem_rd_en    = r_rd_en;
    assign mem_wr_en    = r_wr_en;
    assign mem_wdata    = r_wdata;
    assign protocol_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ext_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_bus_responder
// Summary  : Directed bench for ext_bus_responder; two instances (MEM_LAT 1
//            and 3) share the bus pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_bus_responder;

    logic        clk;
    logic        rst;
    logic        ale, psen_n, rd_n, wr_n;
    logic [7:0]  p0_in, p2_in, mem_rdata;

    logic [7:0]  p0_out, mem_wdata;
    logic        p0_oe, mem_code, mem_rd_en, mem_wr_en, protocol_err;
    logic [15:0] mem_addr;

    logic [7:0]  p0_out3, mem_wdata3;
    logic        p0_oe3, mem_code3, mem_rd_en3, mem_wr_en3, protocol_err3;
    logic [15:0] mem_addr3;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt = 0, wr_cnt = 0, err_cnt = 0, oe_cnt = 0, both_cnt = 0;
    int rd3_cnt = 0, err3_cnt = 0, oe3_cnt = 0;

    ext_bus_responder #(.ADDR_W(16), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n),
        .p0_in(p0_in), .p2_in(p2_in), .p0_out(p0_out), .p0_oe(p0_oe),
        .mem_addr(mem_addr), .mem_code(mem_code), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .protocol_err(protocol_err)
    );

    ext_bus_responder #(.ADDR_W(16), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n),
        .p0_in(p0_in), .p2_in(p2_in), .p0_out(p0_out3), .p0_oe(p0_oe3),
        .mem_addr(mem_addr3), .mem_code(mem_code3), .mem_rd_en(mem_rd_en3),
        .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en3), .mem_wdata(mem_wdata3),
        .protocol_err(protocol_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_rd_en)              rd_cnt   <= rd_cnt + 1;
        if (mem_wr_en)              wr_cnt   <= wr_cnt + 1;
        if (protocol_err)           err_cnt  <= err_cnt + 1;
        if (p0_oe)                  oe_cnt   <= oe_cnt + 1;
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
        if (mem_rd_en3)             rd3_cnt  <= rd3_cnt + 1;
        if (protocol_err3)          err3_cnt <= err3_cnt + 1;
        if (p0_oe3)                 oe3_cnt  <= oe3_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in LATCHED at return; caller drives the strobe for cycle M.
    task automatic latch_addr(input logic [7:0] hi, input logic [7:0] lo);
        ale   = 1'b1;
        p2_in = hi;
        p0_in = lo;
        tick;
        ale   = 1'b0;
        p0_in = 8'hEE;
        tick;
    endtask

    task automatic do_fetch(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] data);
        int b;
        b = rd_cnt;
        mem_rdata = data;
        latch_addr(hi, lo);
        psen_n = 1'b0;
        tick;                                   // M+1
        chk("fetch_rd_en", 32'(mem_rd_en), 32'd1);
        chk("fetch_addr", 32'(mem_addr), 32'({hi, lo}));
        chk("fetch_code", 32'(mem_code), 32'd1);
        chk("fetch_oe_m1", 32'(p0_oe), 32'd0);
        tick;                                   // M+2
        chk("fetch_oe_m2", 32'(p0_oe), 32'd0);
        tick;                                   // M+3
        chk("fetch_oe_m3", 32'(p0_oe), 32'd1);
        chk("fetch_data", 32'(p0_out), 32'(data));
        tick;                                   // M+4
        chk("fetch_oe_m4", 32'(p0_oe), 32'd1);
        psen_n = 1'b1;
        tick;                                   // M+5
        chk("fetch_oe_drop", 32'(p0_oe), 32'd0);
        chk("fetch_rd_count", 32'(rd_cnt - b), 32'd1);
    endtask

    initial begin
        int b_rd, b_wr, b_err, b_oe, b_rd3, b_err3, b_oe3;
        rst = 1'b1; ale = 1'b0; psen_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        p0_in = 8'h00; p2_in = 8'h00; mem_rdata = 8'h00;
        tick; tick;
        chk("rst_ctrl", 32'({p0_oe, mem_rd_en, mem_wr_en, protocol_err, mem_code}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'({p0_out, mem_wdata}), 32'd0);
        rst = 1'b0;
        tick;

        // MOVC fetch
        do_fetch(8'h12, 8'h34, 8'hA5);
        tick; tick; tick;

        // MOVX write
        b_rd = rd_cnt; b_wr = wr_cnt; b_oe = oe_cnt;
        latch_addr(8'h00, 8'hFF);
        wr_n = 1'b0; p0_in = 8'h5C;
        tick;
        chk("wr_early", 32'(mem_wr_en), 32'd0);
        tick;
        wr_n = 1'b1; p0_in = 8'h00;
        tick;
        chk("wr_en", 32'(mem_wr_en), 32'd1);
        chk("wr_data", 32'(mem_wdata), 32'h5C);
        chk("wr_addr", 32'(mem_addr), 32'h00FF);
        chk("wr_code", 32'(mem_code), 32'd0);
        tick;
        chk("wr_en_pulse", 32'(mem_wr_en), 32'd0);
        chk("wr_count", 32'(wr_cnt - b_wr), 32'd1);
        chk("wr_no_rd", 32'(rd_cnt - b_rd), 32'd0);
        chk("wr_no_oe", 32'(oe_cnt - b_oe), 32'd0);
        tick; tick;

        // Aborted read on the MEM_LAT=3 instance
        b_rd3 = rd3_cnt; b_err3 = err3_cnt; b_oe3 = oe3_cnt;
        mem_rdata = 8'h77;
        latch_addr(8'h00, 8'h40);
        rd_n = 1'b0;
        tick;
        chk("abort_rd_en", 32'(mem_rd_en3), 32'd1);
        chk("abort_code", 32'(mem_code3), 32'd0);
        chk("abort_addr", 32'(mem_addr3), 32'h0040);
        tick;
        rd_n = 1'b1;
        tick; tick; tick; tick; tick;
        chk("abort_rd_count", 32'(rd3_cnt - b_rd3), 32'd1);
        chk("abort_no_oe", 32'(oe3_cnt - b_oe3), 32'd0);
        chk("abort_no_err", 32'(err3_cnt - b_err3), 32'd0);
        chk("abort_idle", 32'(dut3.r_state), 32'd0);

        // ALE during RD_DRIVE, then the next access proceeds
        mem_rdata = 8'h3C;
        latch_addr(8'h20, 8'h00);
        psen_n = 1'b0;
        tick; tick; tick;
        chk("viol_oe_before", 32'(p0_oe), 32'd1);
        ale = 1'b1; p2_in = 8'h22; p0_in = 8'h11;
        tick;
        chk("viol_err", 32'(protocol_err), 32'd1);
        chk("viol_oe_off", 32'(p0_oe), 32'd0);
        ale = 1'b0; psen_n = 1'b1;
        tick;
        chk("viol_err_pulse", 32'(protocol_err), 32'd0);
        rd_n = 1'b0;
        tick;
        chk("viol_next_rd_en", 32'(mem_rd_en), 32'd1);
        chk("viol_next_addr", 32'(mem_addr), 32'h2211);
        chk("viol_next_code", 32'(mem_code), 32'd0);
        tick; tick;
        chk("viol_next_oe", 32'(p0_oe), 32'd1);
        chk("viol_next_data", 32'(p0_out), 32'h3C);
        rd_n = 1'b1;
        tick; tick;
        chk("viol_next_drop", 32'(p0_oe), 32'd0);
        tick; tick; tick;

        // PSEN and WR low together
        b_wr = wr_cnt;
        mem_rdata = 8'h9A;
        latch_addr(8'h03, 8'h00);
        psen_n = 1'b0; wr_n = 1'b0;
        tick;
        chk("multi_err", 32'(protocol_err), 32'd1);
        chk("multi_rd_en", 32'(mem_rd_en), 32'd1);
        chk("multi_code", 32'(mem_code), 32'd1);
        chk("multi_addr", 32'(mem_addr), 32'h0300);
        wr_n = 1'b1;
        tick; tick;
        chk("multi_oe", 32'(p0_oe), 32'd1);
        chk("multi_data", 32'(p0_out), 32'h9A);
        psen_n = 1'b1;
        tick; tick;
        chk("multi_no_wr", 32'(wr_cnt - b_wr), 32'd0);
        tick; tick; tick;

        // Reset during WR_ACTIVE
        b_wr = wr_cnt;
        latch_addr(8'h00, 8'h10);
        wr_n = 1'b0; p0_in = 8'h77;
        tick;
        rst = 1'b1;
        tick;
        chk("rstwr_ctrl", 32'({p0_oe, mem_rd_en, mem_wr_en, protocol_err, mem_code}), 32'd0);
        chk("rstwr_addr", 32'(mem_addr), 32'd0);
        chk("rstwr_wdata", 32'(mem_wdata), 32'd0);
        wr_n = 1'b1;
        tick;
        rst = 1'b0;
        tick; tick;
        chk("rstwr_no_wr", 32'(wr_cnt - b_wr), 32'd0);
        chk("rstwr_idle", 32'(dut.r_state), 32'd0);

        // Reset released with ALE high, then a single ALE fall
        b_rd = rd_cnt;
        ale = 1'b1; p2_in = 8'h66; p0_in = 8'h55; rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        ale = 1'b0;
        tick;
        chk("rstale_latched", 32'(dut.r_state), 32'd1);
        tick;
        chk("rstale_hold", 32'(dut.r_state), 32'd1);
        rd_n = 1'b0; mem_rdata = 8'h42;
        tick;
        chk("rstale_rd_en", 32'(mem_rd_en), 32'd1);
        chk("rstale_addr", 32'(mem_addr), 32'h6655);
        tick; tick;
        chk("rstale_data", 32'(p0_out), 32'h42);
        rd_n = 1'b1;
        tick; tick;
        chk("rstale_rd_count", 32'(rd_cnt - b_rd), 32'd1);
        tick; tick; tick;

        // Idle cycle: ALE fall, no strobe, ALE again
        b_rd = rd_cnt; b_wr = wr_cnt; b_err = err_cnt;
        latch_addr(8'h00, 8'h00);
        ale = 1'b1;
        tick;
        chk("idle_back", 32'(dut.r_state), 32'd0);
        ale = 1'b0;
        tick; tick; tick;
        chk("idle_no_rd", 32'(rd_cnt - b_rd), 32'd0);
        chk("idle_no_wr", 32'(wr_cnt - b_wr), 32'd0);
        chk("idle_no_err", 32'(err_cnt - b_err), 32'd0);

        // Back-to-back fetches at the address extremes
        do_fetch(8'h00, 8'h00, 8'h11);
        do_fetch(8'hFF, 8'hFF, 8'hEE);
        tick; tick;

        chk("never_rd_and_wr", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
